// File: rtl/fpu_mant_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mant_pkg
// Description : Shared mantissa widths and divider state encoding for the
//               FPU mantissa datapath (multiplier_24bit / divider_24bit).
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_mant_pkg;

  // Mantissa width including the explicit hidden bit
  localparam int MANT_W = 24;
  // Fraction width once the hidden bit is dropped
  localparam int FRAC_W = MANT_W - 1;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/divider_24bit_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division iteration: compare the partial
//               remainder with the divisor, subtract when it fits, shift left.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int MANT_W = fpu_mant_pkg::MANT_W
) (
  input  logic [MANT_W:0]   rem,
  input  logic [MANT_W-1:0] div,
  output logic [MANT_W:0]   rem_next,
  output logic              q_bit
);

  logic [MANT_W:0] w_diff;

  // Restoring step; rem < 2*div always holds, so the difference fits in
  // MANT_W bits and the shifted result never overflows MANT_W+1 bits
  always_comb begin
    w_diff = rem - {1'b0, div};
    q_bit  = (rem >= {1'b0, div});
    if (q_bit) begin
      rem_next = {w_diff[MANT_W-1:0], 1'b0};
    end else begin
      rem_next = {rem[MANT_W-1:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/divider_24bit.sv
`default_nettype none
// ============================================================================
// Module      : divider_24bit
// Description : Iterative restoring mantissa divider (num1/num2), one
//               quotient bit per cycle. Produces the truncated fraction, a
//               normalize flag for the exponent path and a sticky bit.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_24bit #(
  parameter int MANT_W = fpu_mant_pkg::MANT_W,
  parameter int FRAC_W = fpu_mant_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] num1,
  input  logic [MANT_W-1:0] num2,
  output logic              busy,
  output logic              done,
  output logic [FRAC_W-1:0] resultF,
  output logic              normalize,
  output logic              sticky,
  output logic              invalid
);

  import fpu_mant_pkg::*;

  localparam int CNT_W = $clog2(MANT_W + 1);
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(MANT_W);

  div_state_e        state_q, state_d;
  logic [MANT_W:0]   rem_q, rem_d;
  logic [MANT_W-1:0] div_q, div_d;
  logic [MANT_W:0]   q_q, q_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] result_f_q, result_f_d;
  logic              normalize_q, normalize_d;
  logic              sticky_q, sticky_d;
  logic              invalid_q, invalid_d;

  logic [MANT_W:0]   w_step_rem;
  logic              w_step_bit;
  logic [MANT_W:0]   w_step_q;

  div_step #(
    .MANT_W (MANT_W)
  ) u_div_step (
    .rem      (rem_q),
    .div      (div_q),
    .rem_next (w_step_rem),
    .q_bit    (w_step_bit)
  );

  assign w_step_q = {q_q[MANT_W-1:0], w_step_bit};

  // Next-state, datapath update and result selection
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    div_d       = div_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    result_f_d  = result_f_q;
    normalize_d = normalize_q;
    sticky_d    = sticky_q;
    invalid_d   = invalid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = {1'b0, num1};
          div_d   = num2;
          q_d     = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Both operands must carry the hidden 1
        if (!rem_q[MANT_W-1] || !div_q[MANT_W-1]) begin
          invalid_d   = 1'b1;
          result_f_d  = '0;
          normalize_d = 1'b0;
          sticky_d    = 1'b0;
          state_d     = DONE;
        end else begin
          invalid_d = 1'b0;
          cnt_d     = c_cnt_init;
          state_d   = RUN;
        end
      end
      RUN: begin
        rem_d = w_step_rem;
        q_d   = w_step_q;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Quotient in [0.5,2): drop the integer bit when set, otherwise
          // shift up one place and flag the exponent for a decrement
          if (w_step_q[MANT_W]) begin
            result_f_d  = w_step_q[MANT_W-1:1];
            normalize_d = 1'b0;
            sticky_d    = w_step_q[0] | (|w_step_rem);
          end else begin
            result_f_d  = w_step_q[MANT_W-2:0];
            normalize_d = 1'b1;
            sticky_d    = |w_step_rem;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      div_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      result_f_q  <= '0;
      normalize_q <= 1'b0;
      sticky_q    <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      result_f_q  <= result_f_d;
      normalize_q <= normalize_d;
      sticky_q    <= sticky_d;
      invalid_q   <= invalid_d;
    end
  end

  assign busy      = (state_q == CHECK) || (state_q == RUN);
  assign done      = (state_q == DONE);
  assign resultF   = result_f_q;
  assign normalize = normalize_q;
  assign sticky    = sticky_q;
  assign invalid   = invalid_q;

endmodule
`default_nettype wire
